// File: rtl/l0_skew_buf.sv
// l0_skew_buf: L0 input buffer feeding the west edge of the MAC array.
// ROW independent row FIFOs of BW-bit words, written together, read either
// in parallel (all rows pop on the same edge) or skewed (row i pops i cycles
// after row 0) for systolic feed.
// Optional feature: define L0_OCCUPANCY_EN to add the registered per-row
// occupancy output o_count.
module l0_skew_buf #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROW*BW-1:0]   in,
    input  logic                wr,
    input  logic                rd,
    input  logic                mode,
    output logic [ROW*BW-1:0]   out,
    output logic [ROW-1:0]      o_valid,
    output logic                o_full,
    output logic                o_ready,
    output logic                o_empty,
    output logic                o_busy
`ifdef L0_OCCUPANCY_EN
    ,
    output logic [ROW*(AW+1)-1:0] o_count
`endif
);

    logic [ROW-1:0] empty;
    logic [ROW-1:0] full;
    logic [ROW-1:0] rd_en_q;
    logic [ROW-1:0] rd_en_d;
    logic           mode_q;
    logic           mode_d;
    logic           push;

    // Status flags come straight from the pointers so backpressure is
    // visible in the same cycle the last slot fills.
    assign o_ready = ~|full;
    assign o_full  = &full;
    assign o_empty = &empty;
    assign o_busy  = |rd_en_q;

    // Rows stay write-aligned: if any row is full the whole word is dropped.
    assign push = wr & o_ready;

    // Mode may only change while the read pipeline is idle, so a skew in
    // flight always completes in the mode it started with.
    always_comb begin
        mode_d  = mode_q;
        rd_en_d = rd_en_q;
        if (!o_busy && !rd) begin
            mode_d = mode;
        end
        if (mode_q) begin
            rd_en_d = {rd_en_q[ROW-2:0], rd};
        end else begin
            rd_en_d = {ROW{rd}};
        end
    end

    // Read-enable pipeline and registered mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= 1'b0;
            rd_en_q <= '0;
        end else begin
            mode_q  <= mode_d;
            rd_en_q <= rd_en_d;
        end
    end

    for (genvar gi = 0; gi < ROW; gi++) begin : g_row
        logic [BW-1:0] mem_q [DEPTH];
        logic [AW:0]   wptr_q;
        logic [AW:0]   wptr_d;
        logic [AW:0]   rptr_q;
        logic [AW:0]   rptr_d;
        logic [BW-1:0] data_q;
        logic [BW-1:0] data_d;
        logic          valid_q;
        logic          valid_d;
        logic          pop;

        assign empty[gi] = (wptr_q == rptr_q);
        assign full[gi]  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                           (wptr_q[AW] != rptr_q[AW]);
        // Empty is sampled before the edge, so a push landing on an empty
        // row cannot be popped on that same edge.
        assign pop = rd_en_q[gi] & ~empty[gi];

        // Next pointer and output-register values for this row.
        always_comb begin
            wptr_d  = wptr_q + {{AW{1'b0}}, push};
            rptr_d  = rptr_q + {{AW{1'b0}}, pop};
            data_d  = data_q;
            valid_d = pop;
            if (pop) begin
                data_d = mem_q[rptr_q[AW-1:0]];
            end
        end

        // Row pointers and registered read data; contents are discarded on
        // reset simply by equalising the pointers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        // Storage array write port; no reset needed on the data itself.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= in[gi*BW +: BW];
            end
        end

        assign out[gi*BW +: BW] = data_q;
        assign o_valid[gi]      = valid_q;

`ifdef L0_OCCUPANCY_EN
        logic [AW:0] count_q;
        logic [AW:0] count_d;

        // Occupancy tracks the pointers of the same edge.
        always_comb begin
            count_d = wptr_d - rptr_d;
        end

        // Registered occupancy for this row.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign o_count[gi*(AW+1) +: AW+1] = count_q;
`endif
    end

endmodule

// File: tb/tb_l0_skew_buf.sv
// Directed testbench for l0_skew_buf (ROW=8, BW=4, DEPTH=4).
module tb_l0_skew_buf;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic                clk;
    logic                reset;
    logic [ROW*BW-1:0]   in_w;
    logic                wr;
    logic                rd;
    logic                mode;
    logic [ROW*BW-1:0]   out_w;
    logic [ROW-1:0]      o_valid;
    logic                o_full;
    logic                o_ready;
    logic                o_empty;
    logic                o_busy;
`ifdef L0_OCCUPANCY_EN
    logic [ROW*(AW+1)-1:0] o_count;
`endif

    int total = 0;
    int bad   = 0;

    l0_skew_buf #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_w),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .out     (out_w),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_empty (o_empty),
        .o_busy  (o_busy)
`ifdef L0_OCCUPANCY_EN
        ,
        .o_count (o_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [4];
    logic [ROW*(AW+1)-1:0] cnt_exp;

    initial begin
        words[0] = 32'h13579BDF;
        words[1] = 32'h2468ACE0;
        words[2] = 32'h0F1E2D3C;
        words[3] = 32'hC3D2E1F0;

        reset = 1'b0; in_w = '0; wr = 1'b0; rd = 1'b0; mode = 1'b0;
        #12;
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_full",  64'(o_full),  64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_out",   64'(out_w),   64'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---- parallel mode: two words, two-cycle read ----
        wr = 1'b1; in_w = 32'h76543210; tick();
        in_w = 32'hFEDCBA98; tick();
        wr = 1'b0;
        chk("par_not_empty", 64'(o_empty), 64'd0);
        $display("push 76543210, FEDCBA98 parallel");
        rd = 1'b1; tick();
        chk("par_lat_valid", 64'(o_valid), 64'd0);
        chk("par_busy", 64'(o_busy), 64'd1);
        tick();
        chk("par_out0", 64'(out_w), 64'h76543210);
        chk("par_val0", 64'(o_valid), 64'hFF);
        $display("pop out=%h valid=%h", out_w, o_valid);
        rd = 1'b0; tick();
        chk("par_out1", 64'(out_w), 64'hFEDCBA98);
        chk("par_val1", 64'(o_valid), 64'hFF);
        chk("par_empty", 64'(o_empty), 64'd1);
        $display("pop out=%h valid=%h", out_w, o_valid);
        tick();
        chk("par_idle_valid", 64'(o_valid), 64'd0);
        chk("par_hold_out", 64'(out_w), 64'hFEDCBA98);
        chk("par_idle_busy", 64'(o_busy), 64'd0);

        // ---- skewed mode: one word, single rd pulse ----
        mode = 1'b1; tick();
        wr = 1'b1; in_w = 32'h76543210; tick();
        wr = 1'b0;
        rd = 1'b1; tick();
        rd = 1'b0;
        chk("skw_lat_valid", 64'(o_valid), 64'd0);
        chk("skw_busy0", 64'(o_busy), 64'd1);
        for (int i = 0; i < ROW; i++) begin
            tick();
            chk($sformatf("skw_valid%0d", i), 64'(o_valid), 64'(1) << i);
            chk($sformatf("skw_nib%0d", i), 64'(out_w[i*BW +: BW]), 64'(i));
            chk($sformatf("skw_busy%0d", i + 1), 64'(o_busy), (i < ROW - 1) ? 64'd1 : 64'd0);
            $display("skew step %0d valid=%h out=%h busy=%0d", i, o_valid, out_w, o_busy);
        end
        chk("skw_out_all", 64'(out_w), 64'h76543210);
        chk("skw_empty", 64'(o_empty), 64'd1);

        // ---- fill to full, dropped write, drain, wrap ----
        mode = 1'b0; tick();
        for (int k = 0; k < DEPTH; k++) begin
            wr = 1'b1; in_w = words[k]; tick();
        end
        chk("full_full", 64'(o_full), 64'd1);
        chk("full_ready", 64'(o_ready), 64'd0);
        in_w = 32'hAAAAAAAA; tick();
        wr = 1'b0;
        chk("drop_full", 64'(o_full), 64'd1);
        $display("fill 4 words, drop AAAAAAAA full=%0d", o_full);
        rd = 1'b1; tick();
        chk("drain_lat", 64'(o_valid), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk($sformatf("drain_out%0d", k), 64'(out_w), 64'(words[k]));
            chk($sformatf("drain_val%0d", k), 64'(o_valid), 64'hFF);
            $display("drain %0d out=%h", k, out_w);
            if (k == 2) rd = 1'b0;
        end
        chk("drain_empty", 64'(o_empty), 64'd1);
        chk("drain_ready", 64'(o_ready), 64'd1);
        wr = 1'b1; in_w = 32'h5A5A5A5A; tick();
        in_w = 32'h3C3C3C3C; tick();
        wr = 1'b0;
        chk("wrap_not_full", 64'(o_full), 64'd0);
        rd = 1'b1; tick(); tick();
        chk("wrap_out0", 64'(out_w), 64'h5A5A5A5A);
        rd = 1'b0; tick();
        chk("wrap_out1", 64'(out_w), 64'h3C3C3C3C);
        chk("wrap_empty", 64'(o_empty), 64'd1);
        $display("wrap refill out=%h", out_w);

        // ---- push onto empty row while rd_en is already high ----
        rd = 1'b1; tick();
        wr = 1'b1; in_w = 32'h11111111; rd = 1'b0; tick();
        wr = 1'b0;
        chk("pp_no_valid", 64'(o_valid), 64'd0);
        chk("pp_kept", 64'(o_empty), 64'd0);
        rd = 1'b1; tick();
        rd = 1'b0; tick();
        chk("pp_out", 64'(out_w), 64'h11111111);
        chk("pp_val", 64'(o_valid), 64'hFF);
        $display("push/pop collision then pop out=%h", out_w);

        // ---- mode flip while skew in flight ----
        mode = 1'b1; tick();
        wr = 1'b1; in_w = 32'h76543210; tick();
        wr = 1'b0;
        rd = 1'b1; tick();
        rd = 1'b0; mode = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            tick();
            chk($sformatf("flip_valid%0d", i), 64'(o_valid), 64'(1) << i);
        end
        chk("flip_busy", 64'(o_busy), 64'd0);
        wr = 1'b1; in_w = 32'h89ABCDEF; tick();
        wr = 1'b0;
        rd = 1'b1; tick();
        rd = 1'b0; tick();
        chk("flip_par_valid", 64'(o_valid), 64'hFF);
        chk("flip_par_out", 64'(out_w), 64'h89ABCDEF);
        $display("mode flip after drain valid=%h out=%h", o_valid, out_w);

        // ---- asynchronous reset in the middle of a skew ----
        mode = 1'b1; tick();
        wr = 1'b1; in_w = 32'h01234567; tick();
        in_w = 32'h89ABCDEF; tick();
        wr = 1'b0;
`ifdef L0_OCCUPANCY_EN
        for (int i = 0; i < ROW; i++) cnt_exp[i*(AW+1) +: AW+1] = 3'd2;
        chk("cnt_two", 64'(o_count), 64'(cnt_exp));
`endif
        rd = 1'b1; tick();
        rd = 1'b0; tick();
        chk("rst_mid_pre", 64'(o_valid), 64'h01);
        #2;
        reset = 1'b0;
        #1;
        chk("rstm_valid", 64'(o_valid), 64'd0);
        chk("rstm_out", 64'(out_w), 64'd0);
        chk("rstm_empty", 64'(o_empty), 64'd1);
        chk("rstm_busy", 64'(o_busy), 64'd0);
        chk("rstm_ready", 64'(o_ready), 64'd1);
        chk("rstm_full", 64'(o_full), 64'd0);
`ifdef L0_OCCUPANCY_EN
        chk("rstm_cnt", 64'(o_count), 64'd0);
`endif
        $display("async reset mid skew valid=%h empty=%0d", o_valid, o_empty);
        @(negedge clk);
        reset = 1'b1;
        mode = 1'b0;

        // After reset mode_q is parallel again.
        wr = 1'b1; in_w = 32'hCAFE1234; tick();
        wr = 1'b0;
        rd = 1'b1; tick();
        rd = 1'b0; tick();
        chk("post_rst_out", 64'(out_w), 64'hCAFE1234);
        chk("post_rst_val", 64'(o_valid), 64'hFF);
        $display("post reset parallel pop out=%h", out_w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l0_skew_buf.md
Name: l0_skew_buf

Overview:
- Parametrised successor to the current L0 input buffer: ROW independent row FIFOs of BW-bit words, integrated with no external FIFO instance.
- Sits between the activation/weight SRAM read path and the west edge of the MAC array.
- Read modes: parallel (all rows pop together) and skewed (row i pops i cycles after row 0) for systolic feed.
- Additions over the current block: per-row valid flags, corrected any-row-full backpressure, an empty flag, and a safe mode-change rule.

Parameters:
ROW, 8, number of row FIFOs / array rows (>=2)
BW, 4, bits per row word
DEPTH, 64, entries per row FIFO (power of 2, >=2)
AW, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in  in  ROW*BW  write data; row i = in[BW*(i+1)-1:BW*i]
wr  in  1  push one word into every row
rd  in  1  read request
mode  in  1  0 = parallel read, 1 = skewed read
out  out  ROW*BW  registered read data, same row slicing as in
o_valid  out  ROW  o_valid[i]=1 for exactly the cycle out row i holds newly popped data
o_full  out  1  all rows full
o_ready  out  1  no row full; write accepted
o_empty  out  1  all rows empty
o_busy  out  1  skew pipeline active (|rd_en)

Behaviour:
- Storage per row: DEPTH x BW array; wptr/rptr are AW+1 bits with wrap bit.
  - empty[i] = (wptr==rptr).
  - full[i] = index bits equal and wrap bits differ.
- Write: on a clk edge with wr=1 and o_ready=1, every row stores its slice at wptr and increments wptr.
  - wr=1 with o_ready=0: whole word dropped, no pointer moves, including on non-full rows.
  - Rows stay write-aligned.
- o_ready = ~|full; o_full = &full; o_empty = &empty. All are combinational from pointers.
- mode_q: registered copy of mode. It updates only on edges where o_busy=0 and rd=0; otherwise it holds. A mode flip mid-stream therefore takes effect only after the pipeline drains.
- rd_en[ROW-1:0] register:
  - mode_q=0: rd_en <= {ROW{rd}}.
  - mode_q=1: rd_en[0] <= rd; rd_en[i] <= rd_en[i-1] for i=1..ROW-1.
- Pop: on an edge where rd_en[i]=1 and empty[i]=0, out row i <= mem[rptr], rptr increments, and o_valid[i] <= 1. Otherwise o_valid[i] <= 0 and out row i holds.
- Latency:
  - rd high at edge t gives rd_en high after t.
  - Data and o_valid are visible after edge t+1 in parallel mode.
  - In skewed mode row i is visible after edge t+1+i.
- Pop on empty row: ignored, no underflow, o_valid[i]=0. No error flag.
- Simultaneous push and pop on the same edge: both happen and occupancy is unchanged. If the row was empty before the edge, the pop is blocked and the pushed word stays.
- Full wrap: DEPTH pushes then DEPTH pops return words in order. Pointers wrap through index 0 with the wrap bit toggling.
- Reset (reset=0, asynchronous, any time including mid-stream):
  - All pointers, rd_en, mode_q, out, and o_valid go to 0. FIFO contents are discarded.
  - Resulting outputs: o_empty=1, o_ready=1, o_full=0, o_busy=0.
  - Memory arrays need no reset.

Optional Feature:
- Macro: L0_OCCUPANCY_EN.
- Defined: extra output o_count, width ROW*(AW+1). Slice i = wptr[i]-rptr[i], range 0..DEPTH, registered, updated on the same edge as the pointers.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- ROW=8,BW=4,DEPTH=4, mode=0: push 0x76543210,0xFEDCBA98; rd pulse 2 cycles -> out=0x76543210 with o_valid=0xFF one cycle after rd_en, then 0xFEDCBA98; o_empty=1 afterwards.
- mode=1: push 0x76543210, single rd pulse -> o_valid walks 0x01,0x02,...,0x80 on consecutive cycles; row i nibble equals i; o_busy high 8 cycles.
- Push 4 words -> o_full=1, o_ready=0; 5th wr with 0xAAAAAAAA dropped; 4 pops return the original 4 words in order; pointers wrap correctly on refill.
- Push 0x11111111 and rd in the same cycle on an empty buffer -> no o_valid. Next rd -> out=0x11111111, o_valid=0xFF.
- mode=1 pulse rd, flip mode to 0 while o_busy=1 -> skew completes unchanged. After o_busy=0, next rd gives parallel o_valid=0xFF.
- Assert reset=0 mid skew with 2 words stored -> immediately o_valid=0, out=0, o_empty=1, o_busy=0. With L0_OCCUPANCY_EN, o_count=0.
